// File: rtl/pipe5_types_pkg.sv
// Pipe5-specific types: register selects, forwarding selects and bus arbiter states.
package pipe5_types_pkg;

    import rv32i_types_pkg::*;

    // Architectural register index
    typedef logic [4:0] rsel_t;

    // Operand source chosen by the forwarding unit
    typedef enum logic [1:0] {
        BYP_NONE,
        BYP_EX,
        BYP_MEM,
        BYP_WB
    } bypass_t;

    // Unified-bus arbiter state
    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_t;

endpackage

// File: rtl/rv32i_types_pkg.sv
// Base RV32I width constants and word type shared across the pipe5 core.
package rv32i_types_pkg;

    parameter int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pipe5_mem_arbiter.sv
// Shares the unified memory bus between fetch2 (instruction reads) and the
// memory stage (data loads/stores). One transaction at a time; on contention
// the winner is chosen by FAIR_MODE and the loser is handed the bus in the
// completion cycle with no idle gap.
module pipe5_mem_arbiter
    import rv32i_types_pkg::*;
    import pipe5_types_pkg::*;
#(
    parameter bit FAIR_MODE = 1'b1
) (
    input  logic       CLK,
    input  logic       nRST,
    // fetch2 side
    input  logic       i_ren,
    input  word_t      i_addr,
    output word_t      i_rdata,
    output logic       i_busy,
    // memory-stage side
    input  logic       d_ren,
    input  logic       d_wen,
    input  word_t      d_addr,
    input  word_t      d_wdata,
    input  logic [3:0] d_byte_en,
    output word_t      d_rdata,
    output logic       d_busy,
    // unified bus
    output logic       m_ren,
    output logic       m_wen,
    output word_t      m_addr,
    output word_t      m_wdata,
    output logic [3:0] m_byte_en,
    input  word_t      m_rdata,
    input  logic       m_busy
);

    arb_state_t state;
    logic       last_d;
    logic       d_is_wr;
    logic       i_req;
    logic       d_req;

    assign i_req = i_ren;
    assign d_req = d_ren | d_wen;

    // Arbitration state, last-served side, and the data command captured at grant.
    // The data command is latched so a flushed store/load keeps its bus
    // direction until the transaction completes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            d_is_wr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req && d_req) begin
                        if (FAIR_MODE && last_d) begin
                            state <= GRANT_I;
                        end else begin
                            state   <= GRANT_D;
                            d_is_wr <= d_wen;
                        end
                    end else if (d_req) begin
                        state   <= GRANT_D;
                        d_is_wr <= d_wen;
                    end else if (i_req) begin
                        state <= GRANT_I;
                    end
                end
                GRANT_I: begin
                    if (!m_busy) begin
                        last_d <= 1'b0;
                        if (d_req) begin
                            state   <= GRANT_D;
                            d_is_wr <= d_wen;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GRANT_D: begin
                    if (!m_busy) begin
                        last_d <= 1'b1;
                        state  <= i_req ? GRANT_I : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the granted side onto the bus and report busy/rdata to both sides.
    always_comb begin
        m_ren     = 1'b0;
        m_wen     = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_byte_en = '0;
        i_rdata   = '0;
        d_rdata   = '0;
        i_busy    = i_req;
        d_busy    = d_req;
        unique case (state)
            GRANT_I: begin
                m_ren     = 1'b1;
                m_addr    = i_addr;
                m_byte_en = '1;
                i_busy    = m_busy;
                i_rdata   = m_rdata;
            end
            GRANT_D: begin
                m_ren     = ~d_is_wr;
                m_wen     = d_is_wr;
                m_addr    = d_addr;
                m_wdata   = d_wdata;
                m_byte_en = d_byte_en;
                d_busy    = m_busy;
                d_rdata   = m_rdata;
            end
            default: ;
        endcase
        // While reset is held the requesters must see a quiet arbiter.
        if (!nRST) begin
            i_busy = 1'b0;
            d_busy = 1'b0;
        end
    end

    // Memory stage must never issue a load and a store together.
    assert property (@(posedge CLK) disable iff (!nRST) !(d_ren && d_wen));

endmodule
